pcileech_rst_seq: RTL and testbench
===================================

# pcileech_rst_seq

Power-on and soft-reset sequencer for the PCILeech board top levels. It replaces the inline tick-count reset logic in the top module with a dedicated stage that sits directly upstream of `pcileech_com`, `pcileech_fifo` and `pcileech_pcie_a7`. It produces:
- the system reset `rst`;
- the FT601 pad reset `ft601_rst_n`;
- the power-on LED blink;
- a free-running 64-bit tick count.

The FT601 reset is released before the system reset, so the USB bridge is out of reset when the FIFO and COM logic start.

## Interface
Parameters:
- PARAM_RST_CYCLES, 64: cycles both resets are held after reset deassertion or soft reset (≥1).
- PARAM_SETTLE_CYCLES, 8: cycles `rst` stays high after `ft601_rst_n` is released (≥1).
- PARAM_BLINK_BIT, 24: tick bit that drives the blink.
- PARAM_BLINK_WINDOW_BIT, 27: blink is enabled only while tick[63:PARAM_BLINK_WINDOW_BIT] == 0.

Ports:
- clk  in  1  system clock (100 MHz). Single clock domain.
- rst_n  in  1  reset. Asynchronous, active-low.
- soft_rst_req  in  1  single-cycle request to re-run the reset sequence (from the FIFO command path).
- rst  out  1  system reset, active-high, synchronous to clk.
- ft601_rst_n  out  1  FT601 reset, active-low.
- led_pwronblink  out  1  power-on blink to the COM LED invert input.
- tickcount64  out  64  free-running cycle counter.
- soft_rst_count  out  8  number of accepted soft resets, saturating.

## Operation
- rst_n passes through a 2-flop synchronizer: assertion is asynchronous, deassertion is synchronous. All state uses the synchronized reset, `rst_n_s`.
- Reset values while `rst_n_s` = 0:
  - rst = 1
  - ft601_rst_n = 0
  - led_pwronblink = 0
  - tickcount64 = 0
  - soft_rst_count = 0
  - state = HOLD
  - phase counter cnt = 0
- tickcount64 increments by 1 every cycle and wraps modulo 2^64. It is never cleared by a soft reset.
- led_pwronblink is registered: tick[PARAM_BLINK_BIT] & (tick[63:PARAM_BLINK_WINDOW_BIT] == 0).
- State machine (cnt is wide enough for max(PARAM_RST_CYCLES, PARAM_SETTLE_CYCLES)):
  - HOLD: rst = 1, ft601_rst_n = 0. cnt increments each cycle. When cnt == PARAM_RST_CYCLES−1: go to RELEASE, cnt ← 0, ft601_rst_n ← 1.
  - RELEASE: rst = 1, ft601_rst_n = 1. When cnt == PARAM_SETTLE_CYCLES−1: go to RUN, rst ← 0.
  - RUN: rst = 0, ft601_rst_n = 1. An accepted soft_rst_req causes the next state to be HOLD, with cnt ← 0, rst ← 1, ft601_rst_n ← 0 and soft_rst_count += 1 (saturates at 255).
- soft_rst_req seen in HOLD or RELEASE is ignored: the sequence is not restarted and the request is not counted.
- If rst_n asserts mid-sequence or in RUN, all outputs return to their reset values immediately (asynchronously).

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Define E1 as the first clk edge at which `rst_n_s` is already 1. E1 is the 3rd edge after rst_n rises; synchronizer latency is 2 edges.
- ft601_rst_n rises after edge E(PARAM_RST_CYCLES), which is E64 with defaults.
- rst falls after edge E(PARAM_RST_CYCLES + PARAM_SETTLE_CYCLES), which is E72 with defaults.
- Soft reset:
  - soft_rst_req sampled high at edge S while in RUN.
  - rst = 1 and ft601_rst_n = 0 after edge S.
  - ft601_rst_n rises after edge S + PARAM_RST_CYCLES.
  - rst falls after edge S + PARAM_RST_CYCLES + PARAM_SETTLE_CYCLES.
- tickcount64 equals k after edge Ek.

## Configuration
- Macro: `PCILEECH_RST_SOFTRESET_EN`.
- Defined: soft_rst_req behaves as described above.
- Undefined:
  - soft_rst_req is ignored; the port remains, unused.
  - soft_rst_count is tied to 0.
  - RUN is terminal until rst_n asserts.

## Structure
- Shared package (pcileech_header.svh) holds:
  - the state enum `rst_seq_state_t` {HOLD, RELEASE, RUN};
  - the default cycle constants.
- Sub-module `pcileech_rst_sync`: 2-flop asynchronous-assert / synchronous-deassert reset synchronizer. Reused by other clock domains later.

## Test plan
- **Power-on:** deassert rst_n, defaults → ft601_rst_n rises after E64 and rst falls after E72. tickcount64 == 72 at rst fall.
- **Soft reset in RUN:** soft_rst_req pulse at edge S → rst high after S, ft601_rst_n low after S. Release after S+64 and S+72. soft_rst_count == 1. tickcount64 continues without reset.
- **Soft reset ignored:** soft_rst_req pulses during HOLD and RELEASE → release edges unchanged (E64, E72), soft_rst_count == 0.
- **Mid-sequence async reset:** rst_n low during RELEASE (E66) → rst = 1, ft601_rst_n = 0, tickcount64 = 0 immediately. The sequence restarts from a new E1.
- **Saturation and blink:**
  - 300 soft resets, each after RUN is reached → soft_rst_count == 255.
  - PARAM_BLINK_BIT = 2, PARAM_BLINK_WINDOW_BIT = 5 → led_pwronblink toggles every 4 cycles while tick < 32, then stays 0.
- **Macro undefined:** soft_rst_req pulses in RUN → rst stays 0, soft_rst_count == 0.

Source files
------------

// File: rtl/pcileech_rst_seq_pkg.sv
// Shared types and defaults for the PCILeech reset sequencer.
package pcileech_rst_seq_pkg;

  // Phases of the reset sequence, in the order they are walked through.
  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } rst_seq_state_t;

  localparam int unsigned DEF_RST_CYCLES       = 64;
  localparam int unsigned DEF_SETTLE_CYCLES    = 8;
  localparam int unsigned DEF_BLINK_BIT        = 24;
  localparam int unsigned DEF_BLINK_WINDOW_BIT = 27;

  localparam logic [7:0]  SOFT_RST_COUNT_MAX   = 8'hFF;

  // Phase counter width: it must hold values up to max(a, b) - 1.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/pcileech_rst_sync.sv
// Two-flop reset synchronizer: asserts asynchronously, releases on the
// second clock edge after the raw reset goes high.
module pcileech_rst_sync (
  input  logic clk_i,
  input  logic rst_n_i,
  output logic rst_n_o
);

  logic [1:0] sync_q;

  // Shift a one through two flops so that release is aligned to clk_i.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign rst_n_o = sync_q[1];

endmodule

// File: rtl/pcileech_rst_seq.sv
// Power-on / soft-reset sequencer for the PCILeech top level.
// Releases the FT601 reset first, then the system reset after a settle gap.
// Optional macro PCILEECH_RST_SOFTRESET_EN enables soft_rst_req handling and
// the soft_rst_count counter; without it RUN is terminal until rst_n asserts.
module pcileech_rst_seq
  import pcileech_rst_seq_pkg::*;
#(
  parameter int unsigned PARAM_RST_CYCLES       = DEF_RST_CYCLES,
  parameter int unsigned PARAM_SETTLE_CYCLES    = DEF_SETTLE_CYCLES,
  parameter int unsigned PARAM_BLINK_BIT        = DEF_BLINK_BIT,
  parameter int unsigned PARAM_BLINK_WINDOW_BIT = DEF_BLINK_WINDOW_BIT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        soft_rst_req,
  output logic        rst,
  output logic        ft601_rst_n,
  output logic        led_pwronblink,
  output logic [63:0] tickcount64,
  output logic [7:0]  soft_rst_count
);

  localparam int unsigned      CNT_W       = cnt_width(PARAM_RST_CYCLES, PARAM_SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PARAM_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(PARAM_SETTLE_CYCLES - 1);

  logic             rst_n_s;
  rst_seq_state_t   state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             rst_q;
  logic             ft_rst_n_q;
  logic [63:0]      tick_q;
  logic [63:0]      tick_d;
  logic             led_q;
  logic             led_d;
  logic             soft_req_w;

  pcileech_rst_sync u_rst_sync (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .rst_n_o (rst_n_s)
  );

  // The blink is derived from the next tick value so that it always lines up
  // with the tick count presented on the same cycle.
  assign tick_d = tick_q + 64'd1;
  assign led_d  = tick_d[PARAM_BLINK_BIT] & (tick_d[63:PARAM_BLINK_WINDOW_BIT] == '0);

`ifdef PCILEECH_RST_SOFTRESET_EN
  logic [7:0] soft_cnt_q;

  assign soft_req_w = soft_rst_req & (state_q == RUN);

  // Count accepted soft resets, holding at the top value instead of wrapping.
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      soft_cnt_q <= 8'd0;
    end else if (soft_req_w && (soft_cnt_q != SOFT_RST_COUNT_MAX)) begin
      soft_cnt_q <= soft_cnt_q + 8'd1;
    end
  end

  assign soft_rst_count = soft_cnt_q;
`else
  logic unused_soft_rst_req;

  assign unused_soft_rst_req = soft_rst_req;
  assign soft_req_w          = 1'b0;
  assign soft_rst_count      = 8'd0;
`endif

  // Free-running tick counter and the power-on blink; a soft reset leaves both alone.
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      tick_q <= 64'd0;
      led_q  <= 1'b0;
    end else begin
      tick_q <= tick_d;
      led_q  <= led_d;
    end
  end

  // Reset phase machine: hold both resets, release FT601, settle, then run.
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_q    <= HOLD;
      cnt_q      <= '0;
      rst_q      <= 1'b1;
      ft_rst_n_q <= 1'b0;
    end else begin
      case (state_q)
        HOLD: begin
          if (cnt_q == RST_LAST) begin
            state_q    <= RELEASE;
            cnt_q      <= '0;
            ft_rst_n_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RELEASE: begin
          if (cnt_q == SETTLE_LAST) begin
            state_q <= RUN;
            cnt_q   <= '0;
            rst_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RUN: begin
          if (soft_req_w) begin
            state_q    <= HOLD;
            cnt_q      <= '0;
            rst_q      <= 1'b1;
            ft_rst_n_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= HOLD;
          cnt_q      <= '0;
          rst_q      <= 1'b1;
          ft_rst_n_q <= 1'b0;
        end
      endcase
    end
  end

  assign rst            = rst_q;
  assign ft601_rst_n    = ft_rst_n_q;
  assign led_pwronblink = led_q;
  assign tickcount64    = tick_q;

endmodule

// File: tb/tb_pcileech_rst_seq.sv
// Testbench for pcileech_rst_seq. Two instances share the inputs: one with
// default parameters and one with a fast blink (bit 2, window bit 5).
// The reference model tracks edges elapsed since the sequence last started.
module tb_pcileech_rst_seq;

  localparam int R_CYC = 64;
  localparam int S_CYC = 8;
  localparam int RS    = R_CYC + S_CYC;
`ifdef PCILEECH_RST_SOFTRESET_EN
  localparam bit SOFT_EN = 1'b1;
`else
  localparam bit SOFT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        soft_rst_req = 1'b0;

  logic        rstA, ftA, ledA;
  logic [63:0] tickA;
  logic [7:0]  cntA;
  logic        rstB, ftB, ledB;
  logic [63:0] tickB;
  logic [7:0]  cntB;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int          mStage;
  int          mSeq;
  int          mCnt;
  logic [63:0] mTick;

  pcileech_rst_seq dutA (
    .clk            (clk),
    .rst_n          (rst_n),
    .soft_rst_req   (soft_rst_req),
    .rst            (rstA),
    .ft601_rst_n    (ftA),
    .led_pwronblink (ledA),
    .tickcount64    (tickA),
    .soft_rst_count (cntA)
  );

  pcileech_rst_seq #(
    .PARAM_BLINK_BIT        (2),
    .PARAM_BLINK_WINDOW_BIT (5)
  ) dutB (
    .clk            (clk),
    .rst_n          (rst_n),
    .soft_rst_req   (soft_rst_req),
    .rst            (rstB),
    .ft601_rst_n    (ftB),
    .led_pwronblink (ledB),
    .tickcount64    (tickB),
    .soft_rst_count (cntB)
  );

  always #5 clk = ~clk;

  function automatic logic [74:0] obsA();
    return {rstA, ftA, ledA, tickA, cntA};
  endfunction

  function automatic logic [74:0] obsB();
    return {rstB, ftB, ledB, tickB, cntB};
  endfunction

  // Expected {rst, ft601_rst_n, led, tick, count} from the model
  function automatic logic [74:0] expVec(input int b, input int w);
    logic r, f, l;
    logic [7:0] c;
    r = (mSeq < RS);
    f = (mSeq >= R_CYC);
    l = mTick[b] && ((mTick >> w) == 64'd0);
    c = mCnt[7:0];
    return {r, f, l, mTick, c};
  endfunction

  task automatic modelReset();
    mStage = 0;
    mSeq   = 0;
    mCnt   = 0;
    mTick  = 64'd0;
  endtask

  task automatic modelEdge(input bit req);
    if (!rst_n) begin
      modelReset();
    end else if (mStage < 2) begin
      mStage++;
    end else begin
      mTick = mTick + 64'd1;
      if (SOFT_EN && req && (mSeq >= RS)) begin
        mSeq = 0;
        if (mCnt < 255) mCnt++;
      end else if (mSeq < RS) begin
        mSeq++;
      end
    end
  endtask

  task automatic cycle(input bit req);
    soft_rst_req = req;
    @(posedge clk);
    modelEdge(req);
    #1;
  endtask

  task automatic assertReset();
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
  endtask

  task automatic releaseReset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(1'($urandom_range(0, 1)));
      if (i >= 2) begin
        checks++;
        if (obsA() !== expVec(24, 27)) begin
          failures++;
          $display("[TB] FAIL reset_A cyc=%0d got=%h exp=%h", i, obsA(), expVec(24, 27));
        end
        checks++;
        if (obsB() !== expVec(2, 5)) begin
          failures++;
          $display("[TB] FAIL reset_B cyc=%0d got=%h exp=%h", i, obsB(), expVec(2, 5));
        end
      end
    end
    soft_rst_req = 1'b0;
  endtask

  task automatic test_power_on();
    int ftEdge, rstEdge;
    logic [63:0] rstTick;
    ftEdge = -1;
    rstEdge = -1;
    rstTick = '1;
    releaseReset();
    for (int i = 1; i <= 90; i++) begin
      cycle(1'b0);
      checks++;
      if (obsA() !== expVec(24, 27)) begin
        failures++;
        $display("[TB] FAIL power_on_A edge=%0d got=%h exp=%h", i, obsA(), expVec(24, 27));
      end
      checks++;
      if (obsB() !== expVec(2, 5)) begin
        failures++;
        $display("[TB] FAIL power_on_B edge=%0d got=%h exp=%h", i, obsB(), expVec(2, 5));
      end
      if (ftA === 1'b1 && ftEdge < 0) ftEdge = i;
      if (rstA === 1'b0 && rstEdge < 0) begin
        rstEdge = i;
        rstTick = tickA;
      end
    end
    checks++;
    if (ftEdge != 2 + R_CYC) begin
      failures++;
      $display("[TB] FAIL power_on_ft_edge got=%0d exp=%0d", ftEdge, 2 + R_CYC);
    end
    checks++;
    if (rstEdge != 2 + RS) begin
      failures++;
      $display("[TB] FAIL power_on_rst_edge got=%0d exp=%0d", rstEdge, 2 + RS);
    end
    checks++;
    if (rstTick !== 64'd72) begin
      failures++;
      $display("[TB] FAIL power_on_tick_at_rst got=%0d exp=72", rstTick);
    end
  endtask

  task automatic test_soft_ignored();
    int ftEdge, guard;
    ftEdge = -1;
    guard = 0;
    assertReset();
    cycle(1'b0);
    cycle(1'b0);
    releaseReset();
    while (!(mStage == 2 && mSeq >= RS) && guard < 200) begin
      guard++;
      cycle(1'($urandom_range(0, 1)));
      checks++;
      if (obsA() !== expVec(24, 27)) begin
        failures++;
        $display("[TB] FAIL soft_ignored_A edge=%0d got=%h exp=%h", guard, obsA(), expVec(24, 27));
      end
      checks++;
      if (obsB() !== expVec(2, 5)) begin
        failures++;
        $display("[TB] FAIL soft_ignored_B edge=%0d got=%h exp=%h", guard, obsB(), expVec(2, 5));
      end
      if (ftA === 1'b1 && ftEdge < 0) ftEdge = guard;
    end
    soft_rst_req = 1'b0;
    checks++;
    if (ftEdge != 2 + R_CYC) begin
      failures++;
      $display("[TB] FAIL soft_ignored_ft_edge got=%0d exp=%0d", ftEdge, 2 + R_CYC);
    end
    checks++;
    if (rstA !== 1'b0 || cntA !== 8'd0) begin
      failures++;
      $display("[TB] FAIL soft_ignored_run got rst=%b cnt=%0d exp rst=0 cnt=0", rstA, cntA);
    end
  endtask

  task automatic test_soft_in_run();
    int ftRise, rstFall, gap;
    logic prevFt, prevRst;
    logic [63:0] tickBefore;
    ftRise = -1;
    rstFall = -1;
    gap = $urandom_range(0, 20);
    for (int i = 0; i < gap; i++) cycle(1'b0);
    tickBefore = tickA;
    cycle(1'b1);
    soft_rst_req = 1'b0;
    checks++;
    if (rstA !== SOFT_EN || ftA !== !SOFT_EN) begin
      failures++;
      $display("[TB] FAIL soft_run_after_S got rst=%b ft=%b exp rst=%b ft=%b", rstA, ftA, SOFT_EN, !SOFT_EN);
    end
    checks++;
    if (tickA !== tickBefore + 64'd1) begin
      failures++;
      $display("[TB] FAIL soft_run_tick got=%0d exp=%0d", tickA, tickBefore + 64'd1);
    end
    prevFt = ftA;
    prevRst = rstA;
    for (int j = 1; j <= 90; j++) begin
      cycle(1'b0);
      checks++;
      if (obsA() !== expVec(24, 27)) begin
        failures++;
        $display("[TB] FAIL soft_run_A j=%0d got=%h exp=%h", j, obsA(), expVec(24, 27));
      end
      checks++;
      if (obsB() !== expVec(2, 5)) begin
        failures++;
        $display("[TB] FAIL soft_run_B j=%0d got=%h exp=%h", j, obsB(), expVec(2, 5));
      end
      if (!prevFt && ftA === 1'b1 && ftRise < 0) ftRise = j;
      if (prevRst && rstA === 1'b0 && rstFall < 0) rstFall = j;
      prevFt = ftA;
      prevRst = rstA;
    end
    checks++;
    if (ftRise != (SOFT_EN ? R_CYC : -1)) begin
      failures++;
      $display("[TB] FAIL soft_run_ft_rise got=%0d exp=%0d", ftRise, SOFT_EN ? R_CYC : -1);
    end
    checks++;
    if (rstFall != (SOFT_EN ? RS : -1)) begin
      failures++;
      $display("[TB] FAIL soft_run_rst_fall got=%0d exp=%0d", rstFall, SOFT_EN ? RS : -1);
    end
    checks++;
    if (cntA !== (SOFT_EN ? 8'd1 : 8'd0)) begin
      failures++;
      $display("[TB] FAIL soft_run_count got=%0d exp=%0d", cntA, SOFT_EN ? 1 : 0);
    end
  endtask

  task automatic test_async_mid();
    int guard;
    guard = 0;
    assertReset();
    cycle(1'b0);
    cycle(1'b0);
    releaseReset();
    while (!(mStage == 2 && mSeq == R_CYC + 2) && guard < 200) begin
      guard++;
      cycle(1'b0);
    end
    checks++;
    if (ftA !== 1'b1 || rstA !== 1'b1) begin
      failures++;
      $display("[TB] FAIL async_mid_in_release got rst=%b ft=%b exp rst=1 ft=1", rstA, ftA);
    end
    assertReset();
    checks++;
    if (obsA() !== expVec(24, 27)) begin
      failures++;
      $display("[TB] FAIL async_mid_immediate_A got=%h exp=%h", obsA(), expVec(24, 27));
    end
    checks++;
    if (obsB() !== expVec(2, 5)) begin
      failures++;
      $display("[TB] FAIL async_mid_immediate_B got=%h exp=%h", obsB(), expVec(2, 5));
    end
    cycle(1'b0);
    cycle(1'b0);
    releaseReset();
    for (int i = 1; i <= 80; i++) begin
      cycle(1'($urandom_range(0, 1)));
      checks++;
      if (obsA() !== expVec(24, 27)) begin
        failures++;
        $display("[TB] FAIL async_mid_restart_A edge=%0d got=%h exp=%h", i, obsA(), expVec(24, 27));
      end
    end
    soft_rst_req = 1'b0;
  endtask

  task automatic test_saturation();
    int guard, gap, width;
    assertReset();
    cycle(1'b0);
    cycle(1'b0);
    releaseReset();
    for (int k = 0; k < 300; k++) begin
      guard = 0;
      while (!(mStage == 2 && mSeq >= RS) && guard < 200) begin
        guard++;
        cycle(1'b0);
        checks++;
        if (obsA() !== expVec(24, 27)) begin
          failures++;
          $display("[TB] FAIL saturation_A k=%0d got=%h exp=%h", k, obsA(), expVec(24, 27));
        end
      end
      gap = $urandom_range(0, 3);
      width = $urandom_range(1, 2);
      for (int i = 0; i < gap; i++) cycle(1'b0);
      for (int i = 0; i < width; i++) cycle(1'b1);
      soft_rst_req = 1'b0;
      checks++;
      if (obsB() !== expVec(2, 5)) begin
        failures++;
        $display("[TB] FAIL saturation_B k=%0d got=%h exp=%h", k, obsB(), expVec(2, 5));
      end
    end
    checks++;
    if (cntA !== (SOFT_EN ? 8'd255 : 8'd0)) begin
      failures++;
      $display("[TB] FAIL saturation_count got=%0d exp=%0d", cntA, SOFT_EN ? 255 : 0);
    end
  endtask

  task automatic test_blink();
    int toggles;
    logic prevLed;
    toggles = 0;
    assertReset();
    cycle(1'b0);
    cycle(1'b0);
    releaseReset();
    prevLed = ledB;
    for (int i = 1; i <= 62; i++) begin
      cycle(1'b0);
      checks++;
      if (obsB() !== expVec(2, 5)) begin
        failures++;
        $display("[TB] FAIL blink_B edge=%0d got=%h exp=%h", i, obsB(), expVec(2, 5));
      end
      if (ledB !== prevLed) toggles++;
      prevLed = ledB;
    end
    checks++;
    if (toggles != 8) begin
      failures++;
      $display("[TB] FAIL blink_toggles got=%0d exp=8", toggles);
    end
    checks++;
    if (ledB !== 1'b0 || ledA !== 1'b0) begin
      failures++;
      $display("[TB] FAIL blink_window_closed got ledB=%b ledA=%b exp 0 0", ledB, ledA);
    end
  endtask

  initial begin
    modelReset();
    $display("[TB] starting, soft reset feature = %0d", SOFT_EN);
    test_reset();
    test_power_on();
    test_soft_ignored();
    test_soft_in_run();
    test_async_mid();
    test_saturation();
    test_blink();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
